// File: rtl/hls_txn_loop_monitor.sv
// Activity monitor for one HLS kernel with a single II=1 pipelined loop.
// Observes ap_* handshake, loop taps and FSM state; keeps saturating counters.
//
// Ports:
//   clock, reset (async, active-low)
//   ap_start/ap_ready/ap_done/ap_continue : kernel block handshake (observed)
//   cur_state, iter_start/iter_end/quit_state : FSM state and event codes
//   *_block, *_enable : pipeline stall and enable taps
//   loop_start/ready/done/continue, quit_at_end : loop handshake
//   finish : freezes the monitor until reset
//   mod_state, loop_active, *_cnt, busy_cycles, *_pulse, frozen : status
module hls_txn_loop_monitor #(
  parameter int STATE_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  input  logic               finish,
  output logic [1:0]         mod_state,
  output logic               loop_active,
  output logic [CNT_W-1:0]   txn_start_cnt,
  output logic [CNT_W-1:0]   txn_done_cnt,
  output logic [CNT_W-1:0]   iter_start_cnt,
  output logic [CNT_W-1:0]   iter_end_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   busy_cycles,
  output logic               iter_start_pulse,
  output logic               iter_end_pulse,
  output logic               quit_pulse,
  output logic               frozen
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nx;
  logic             w_inc_ts;
  logic             w_inc_td;
  logic             w_busy;

  logic             w_ev_is;
  logic             w_ev_ie;
  logic             w_ev_q;
  logic             w_ev_stall;
  logic             w_loop_clr;

  logic             r_frozen;
  logic             r_loop;
  logic             r_p_is;
  logic             r_p_ie;
  logic             r_p_q;

  logic [CNT_W-1:0] r_ts;
  logic [CNT_W-1:0] r_td;
  logic [CNT_W-1:0] r_is;
  logic [CNT_W-1:0] r_ie;
  logic [CNT_W-1:0] r_st;
  logic [CNT_W-1:0] r_busy;

  // Informational handshakes that do not affect any state.
  logic w_unused;
  assign w_unused = ^{ap_ready, loop_ready};

  function automatic logic [CNT_W-1:0] f_sat(
    input logic [CNT_W-1:0] v,
    input logic             inc
  );
    if (inc && (v != {CNT_W{1'b1}}))
      return v + ONE;
    return v;
  endfunction

  // Loop event decode from FSM state and pipeline taps.
  assign w_ev_is = (cur_state == iter_start_state)
                 & iter_start_enable
                 & ~iter_start_block;
  assign w_ev_ie = (cur_state == iter_end_state)
                 & iter_end_enable
                 & ~iter_end_block;
  assign w_ev_q  = (cur_state == quit_state)
                 & quit_enable
                 & ~quit_block
                 & quit_at_end;
  assign w_ev_stall = (cur_state == iter_start_state)
                    & iter_start_block
                    & (iter_start_enable | iter_end_enable);

  assign w_loop_clr = (loop_done & loop_continue) | w_ev_q;
  assign w_busy     = (r_state != S_IDLE);

  // Transaction FSM: next state and counter strobes.
  always_comb begin
    w_state_nx = r_state;
    w_inc_ts   = 1'b0;
    w_inc_td   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (ap_start) begin
          w_state_nx = S_BUSY;
          w_inc_ts   = 1'b1;
        end
      end
      S_BUSY: begin
        if (ap_done) begin
          if (ap_continue) begin
            w_inc_td = 1'b1;
            if (ap_start)
              w_inc_ts = 1'b1;
            else
              w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A new ap_start is not accepted until the result is consumed.
        if (ap_continue) begin
          w_inc_td   = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else if (!r_frozen) begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_frozen <= 1'b0;
    end else if (finish) begin
      r_frozen <= 1'b1;
    end
  end

  // Clear has priority over a simultaneous loop_start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_loop <= 1'b0;
    end else if (!r_frozen) begin
      if (w_loop_clr)
        r_loop <= 1'b0;
      else if (loop_start)
        r_loop <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_p_is <= 1'b0;
      r_p_ie <= 1'b0;
      r_p_q  <= 1'b0;
    end else if (r_frozen) begin
      r_p_is <= 1'b0;
      r_p_ie <= 1'b0;
      r_p_q  <= 1'b0;
    end else begin
      r_p_is <= w_ev_is;
      r_p_ie <= w_ev_ie;
      r_p_q  <= w_ev_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ts   <= '0;
      r_td   <= '0;
      r_is   <= '0;
      r_ie   <= '0;
      r_st   <= '0;
      r_busy <= '0;
    end else if (!r_frozen) begin
      r_ts   <= f_sat(r_ts, w_inc_ts);
      r_td   <= f_sat(r_td, w_inc_td);
      r_is   <= f_sat(r_is, w_ev_is);
      r_ie   <= f_sat(r_ie, w_ev_ie);
      r_st   <= f_sat(r_st, w_ev_stall);
      r_busy <= f_sat(r_busy, w_busy);
    end
  end

  assign mod_state      = r_state;
  assign loop_active    = r_loop;
  assign txn_start_cnt  = r_ts;
  assign txn_done_cnt   = r_td;
  assign iter_start_cnt = r_is;
  assign iter_end_cnt   = r_ie;
  assign stall_cnt      = r_st;
  assign busy_cycles    = r_busy;
  assign frozen         = r_frozen;

  // The pulse captured on the finish edge is masked once frozen.
  assign iter_start_pulse = r_p_is & ~r_frozen;
  assign iter_end_pulse   = r_p_ie & ~r_frozen;
  assign quit_pulse       = r_p_q  & ~r_frozen;

endmodule

// File: tb/tb_hls_txn_loop_monitor.sv
// Bench for hls_txn_loop_monitor: a 32-bit and a 2-bit counter instance
// share directed stimulus and are compared each cycle to a phase model.
module tb_hls_txn_loop_monitor;

  localparam int SW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ap_start, ap_ready, ap_done, ap_continue;
  logic [SW-1:0] cur_state, is_st, ie_st, q_st;
  logic          isb, ieb, qb, ise, iee, qe;
  logic          loop_start, loop_ready, loop_done, loop_continue;
  logic          quit_at_end, finish;

  logic [1:0]  mod_state, s_mod_state;
  logic        loop_active, s_loop_active;
  logic [31:0] ts_c, td_c, is_c, ie_c, st_c, bz_c;
  logic [1:0]  s_ts, s_td, s_is, s_ie, s_st, s_bz;
  logic        p_is, p_ie, p_q, frz;
  logic        s_p_is, s_p_ie, s_p_q, s_frz;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  hls_txn_loop_monitor #(.STATE_W(SW), .CNT_W(32)) u_dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(is_st),
    .iter_end_state(ie_st), .quit_state(q_st),
    .iter_start_block(isb), .iter_end_block(ieb), .quit_block(qb),
    .iter_start_enable(ise), .iter_end_enable(iee), .quit_enable(qe),
    .loop_start(loop_start), .loop_ready(loop_ready),
    .loop_done(loop_done), .loop_continue(loop_continue),
    .quit_at_end(quit_at_end), .finish(finish),
    .mod_state(mod_state), .loop_active(loop_active),
    .txn_start_cnt(ts_c), .txn_done_cnt(td_c),
    .iter_start_cnt(is_c), .iter_end_cnt(ie_c),
    .stall_cnt(st_c), .busy_cycles(bz_c),
    .iter_start_pulse(p_is), .iter_end_pulse(p_ie),
    .quit_pulse(p_q), .frozen(frz)
  );

  hls_txn_loop_monitor #(.STATE_W(SW), .CNT_W(2)) u_sat (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(is_st),
    .iter_end_state(ie_st), .quit_state(q_st),
    .iter_start_block(isb), .iter_end_block(ieb), .quit_block(qb),
    .iter_start_enable(ise), .iter_end_enable(iee), .quit_enable(qe),
    .loop_start(loop_start), .loop_ready(loop_ready),
    .loop_done(loop_done), .loop_continue(loop_continue),
    .quit_at_end(quit_at_end), .finish(finish),
    .mod_state(s_mod_state), .loop_active(s_loop_active),
    .txn_start_cnt(s_ts), .txn_done_cnt(s_td),
    .iter_start_cnt(s_is), .iter_end_cnt(s_ie),
    .stall_cnt(s_st), .busy_cycles(s_bz),
    .iter_start_pulse(s_p_is), .iter_end_pulse(s_p_ie),
    .quit_pulse(s_p_q), .frozen(s_frz)
  );

  // Behavioural model: true (unbounded) event counts plus transaction phase.
  int m_ts, m_td, m_is, m_ie, m_st, m_bz;
  bit m_txn, m_wait, m_act, m_frz, m_pis, m_pie, m_pq;
  bit e_is, e_ie, e_q, e_st;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ts = 0; m_td = 0; m_is = 0; m_ie = 0; m_st = 0; m_bz = 0;
      m_txn = 0; m_wait = 0; m_act = 0; m_frz = 0;
      m_pis = 0; m_pie = 0; m_pq = 0;
    end else if (!m_frz) begin
      e_is = cur_state == is_st && ise && !isb;
      e_ie = cur_state == ie_st && iee && !ieb;
      e_q  = cur_state == q_st && qe && !qb && quit_at_end;
      e_st = cur_state == is_st && isb && (ise || iee);
      m_pis = e_is; m_pie = e_ie; m_pq = e_q;
      m_is += int'(e_is); m_ie += int'(e_ie); m_st += int'(e_st);
      if (m_txn || m_wait) m_bz++;
      if (m_wait) begin
        if (ap_continue) begin m_td++; m_wait = 0; end
      end else if (m_txn) begin
        if (ap_done && ap_continue) begin
          m_td++;
          if (ap_start) m_ts++;
          else m_txn = 0;
        end else if (ap_done) begin
          m_txn = 0; m_wait = 1;
        end
      end else if (ap_start) begin
        m_ts++; m_txn = 1;
      end
      if ((loop_done && loop_continue) || e_q) m_act = 0;
      else if (loop_start) m_act = 1;
      if (finish) m_frz = 1;
    end
  end

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [1:0] ms;
    ms = m_wait ? 2'd2 : (m_txn ? 2'd1 : 2'd0);
    chk("mod_state", 64'(mod_state), 64'(ms));
    chk("loop_active", 64'(loop_active), 64'(m_act));
    chk("frozen", 64'(frz), 64'(m_frz));
    chk("txn_start", 64'(ts_c), 64'(m_ts));
    chk("txn_done", 64'(td_c), 64'(m_td));
    chk("iter_start", 64'(is_c), 64'(m_is));
    chk("iter_end", 64'(ie_c), 64'(m_ie));
    chk("stall", 64'(st_c), 64'(m_st));
    chk("busy", 64'(bz_c), 64'(m_bz));
    chk("p_is", 64'(p_is), 64'(m_pis && !m_frz));
    chk("p_ie", 64'(p_ie), 64'(m_pie && !m_frz));
    chk("p_q", 64'(p_q), 64'(m_pq && !m_frz));
    chk("sat_ts", 64'(s_ts), 64'(sat3(m_ts)));
    chk("sat_td", 64'(s_td), 64'(sat3(m_td)));
    chk("sat_is", 64'(s_is), 64'(sat3(m_is)));
    chk("sat_ie", 64'(s_ie), 64'(sat3(m_ie)));
    chk("sat_st", 64'(s_st), 64'(sat3(m_st)));
    chk("sat_bz", 64'(s_bz), 64'(sat3(m_bz)));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    cur_state = '0; isb = 0; ieb = 0; qb = 0;
    ise = 0; iee = 0; qe = 0;
    loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0;
    quit_at_end = 0; finish = 0;
  endtask

  task automatic rnd();
    logic [31:0] rv;
    rv = $urandom;
    ap_start = rv[0]; ap_ready = rv[1]; ap_done = rv[2];
    ap_continue = rv[3]; cur_state = rv[6:4];
    isb = rv[7]; ieb = rv[8]; qb = rv[9];
    ise = rv[10]; iee = rv[11]; qe = rv[12];
    loop_start = rv[13]; loop_ready = rv[14]; loop_done = rv[15];
    loop_continue = rv[16]; quit_at_end = rv[17]; finish = rv[18];
  endtask

  initial begin
    is_st = 3'd2; ie_st = 3'd2; q_st = 3'd2;
    clr();
    // Reset held with random activity.
    for (int i = 0; i < 5; i++) begin rnd(); tick(); end
    chk("rst_mod", 64'(mod_state), 64'd0);
    chk("rst_is", 64'(is_c), 64'd0);
    chk("rst_frz", 64'(frz), 64'd0);
    clr(); reset = 1;
    tick(); tick();
    chk("idle_bz", 64'(bz_c), 64'd0);

    // Single transaction: 4 iterations, end enable lags 3 cycles.
    clr(); ap_start = 1; cur_state = 1; tick();
    clr(); cur_state = 2; ise = 1; loop_start = 1; tick();
    chk("c3_pis", 64'(p_is), 64'd1);
    chk("c3_loop", 64'(loop_active), 64'd1);
    clr(); cur_state = 2; ise = 1; tick();
    clr(); cur_state = 2; ise = 1; tick();
    chk("c5_pis", 64'(p_is), 64'd1);
    clr(); cur_state = 2; ise = 1; iee = 1; tick();
    chk("c6_pie", 64'(p_ie), 64'd1);
    clr(); cur_state = 2; iee = 1; tick();
    clr(); cur_state = 2; iee = 1; tick();
    clr(); cur_state = 2; iee = 1; qe = 1; quit_at_end = 1; tick();
    chk("c9_pq", 64'(p_q), 64'd1);
    chk("c9_loop", 64'(loop_active), 64'd0);
    clr(); ap_done = 1; ap_continue = 1; tick();
    clr(); tick();
    chk("t1_is", 64'(is_c), 64'd4);
    chk("t1_ie", 64'(ie_c), 64'd4);
    chk("t1_ts", 64'(ts_c), 64'd1);
    chk("t1_td", 64'(td_c), 64'd1);
    chk("t1_bz", 64'(bz_c), 64'd8);
    chk("t1_mod", 64'(mod_state), 64'd0);
    chk("t1_sat_is", 64'(s_is), 64'd3);

    // Stall mid-loop, then continue back-pressure.
    clr(); ap_start = 1; cur_state = 1; tick();
    clr(); cur_state = 2; ise = 1; loop_start = 1; tick();
    clr(); cur_state = 2; ise = 1; tick();
    for (int i = 0; i < 3; i++) begin
      clr(); cur_state = 2; ise = 1; isb = 1; tick();
      chk("stall_pis", 64'(p_is), 64'd0);
    end
    chk("stall_cnt", 64'(st_c), 64'd3);
    chk("stall_is", 64'(is_c), 64'd6);
    clr(); cur_state = 2; ise = 1; tick();
    clr(); cur_state = 2; iee = 1; tick();
    clr(); cur_state = 2; iee = 1; tick();
    clr(); cur_state = 2; iee = 1; qe = 1; quit_at_end = 1; tick();
    clr(); ap_done = 1; tick();
    chk("w1_mod", 64'(mod_state), 64'd2);
    clr(); ap_done = 1; ap_start = 1; tick();
    chk("w2_mod", 64'(mod_state), 64'd2);
    chk("w2_td", 64'(td_c), 64'd1);
    clr(); ap_done = 1; ap_continue = 1; tick();
    chk("w3_mod", 64'(mod_state), 64'd0);
    chk("w3_td", 64'(td_c), 64'd2);
    chk("w3_ts", 64'(ts_c), 64'd2);
    clr(); tick();
    chk("t2_is", 64'(is_c), 64'd7);
    chk("t2_ie", 64'(ie_c), 64'd7);
    chk("t2_bz", 64'(bz_c), 64'd20);

    // Back-to-back transactions, then ap_done while idle.
    clr(); ap_start = 1; tick();
    clr(); tick();
    clr(); ap_done = 1; ap_continue = 1; ap_start = 1; tick();
    chk("b2b_mod", 64'(mod_state), 64'd1);
    chk("b2b_ts", 64'(ts_c), 64'd4);
    clr(); ap_done = 1; ap_continue = 1; tick();
    clr(); ap_done = 1; ap_continue = 1; tick();
    chk("idle_done_td", 64'(td_c), 64'd4);
    chk("b2b_bz", 64'(bz_c), 64'd23);

    // Freeze mid-loop.
    clr(); ap_start = 1; cur_state = 1; tick();
    clr(); cur_state = 2; ise = 1; loop_start = 1; tick();
    clr(); cur_state = 2; ise = 1; finish = 1; tick();
    chk("f_frz", 64'(frz), 64'd1);
    chk("f_is", 64'(is_c), 64'd9);
    chk("f_pis", 64'(p_is), 64'd0);
    for (int i = 0; i < 20; i++) begin rnd(); tick(); end
    chk("f20_frz", 64'(frz), 64'd1);
    chk("f20_is", 64'(is_c), 64'd9);
    chk("f20_ts", 64'(ts_c), 64'd5);
    chk("f20_bz", 64'(bz_c), 64'd25);
    chk("f20_mod", 64'(mod_state), 64'd1);
    chk("f20_loop", 64'(loop_active), 64'd1);

    // Reset mid-transaction clears the freeze and starts idle.
    clr(); ap_start = 1; reset = 0; tick();
    clr(); reset = 1; tick();
    chk("r_frz", 64'(frz), 64'd0);
    chk("r_mod", 64'(mod_state), 64'd0);
    chk("r_ts", 64'(ts_c), 64'd0);
    clr(); ap_start = 1; tick();
    chk("r2_ts", 64'(ts_c), 64'd1);
    clr(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
